crc_slice_table_gen: RTL
========================

Name: crc_slice_table_gen

Overview:
- Parametrised successor to the fixed CRC slicing lookup ROMs used by the pipelined LUT-CRC datapath.
- Builds its own 256-entry table in hardware from a polynomial and a byte-advance count. Fill runs automatically after reset and can be repeated at runtime on command.
- After the fill, serves LANES independent lookups per cycle through registered read ports.
- One instance replaces every hard-coded per-stage table, including across CRC widths and polynomials.

Parameters:
CRC_W, 32, CRC width in bits (8..32).
POLY, 32'h04C11DB7, polynomial used after reset (MSB-first, implicit x^CRC_W term, low CRC_W bits used).
SHIFT, 0, zero bytes the entry is advanced past after reset (0 = plain byte table).
SHIFT_W, 5, width of cfg_shift.
LANES, 4, number of parallel lookup ports.

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-high despite the name
cfg_valid  in  1  request table regeneration
cfg_ready  out  1  high in READY; cfg accepted when cfg_valid&&cfg_ready
cfg_poly  in  CRC_W  new polynomial
cfg_shift  in  SHIFT_W  new byte-advance count
busy  out  1  table fill in progress
rd_req  in  LANES  per-lane lookup request
rd_addr  in  LANES*8  per-lane table index (lane n at [8n+7:8n])
rd_valid  out  LANES  per-lane data valid
rd_data  out  LANES*CRC_W  per-lane entry (lane n at [CRC_W*n+CRC_W-1:CRC_W*n])

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Entry definition: T[i] = (i << (CRC_W-8)) passed through N = 8*(s+1) MSB-first LFSR steps with poly p.
  - One step: x = x[CRC_W-1] ? ((x<<1) ^ p) : (x<<1), truncated to CRC_W bits.
  - p and s are the active config.
- Reset, sampled on any edge with rstn=1:
  - active config = POLY/SHIFT; state FILL; idx=0; busy=1; cfg_ready=0; rd_valid=0; rd_data=0.
  - Table contents are don't-care until the fill completes.
- FSM states: FILL_LOAD, FILL_STEP, READY.
  - FILL_LOAD: work = idx << (CRC_W-8); cnt = N-1; go to FILL_STEP.
  - FILL_STEP: one LFSR step per cycle, cnt decrements. On the step with cnt==0, write mem[idx] = stepped value.
    - If idx==255: go to READY, busy=0, cfg_ready=1.
    - Else: idx++ and go to FILL_LOAD.
  - Per entry: N+1 cycles. Full fill: 256*(N+1) cycles. s=0 gives 2304 cycles; s=1 gives 4352.
  - READY: on cfg_valid, latch cfg_poly/cfg_shift as the active config, idx=0, go to FILL_LOAD. busy rises on the next cycle.
  - cfg_valid outside READY is ignored. It is not queued.
- Lookups:
  - Latency 1. On an edge with rd_req[n]=1 in READY: rd_valid[n]=1 and rd_data lane n = mem[rd_addr lane n].
  - rd_req[n]=0 gives rd_valid[n]=0; rd_data lane n holds its last value.
  - All lanes are independent and may address the same index in the same cycle.
  - Requests while busy=1 are dropped: rd_valid=0, no data update. The datapath must gate on busy.
  - A lookup and an accepted cfg in the same READY cycle: the lookup completes with the old table, and the fill starts.
- Reset during a fill aborts it and restarts the fill with the defaults. Partial entries are never exposed because busy stays high.
- Widths: i is zero-extended to CRC_W before the shift.
- cfg_shift=0 and SHIFT=0 are legal (N=8). The max cfg_shift gives N = 8*2^SHIFT_W.

Decomposition:
- Shared package crc_pkg:
  - FSM state enum (FILL_LOAD, FILL_STEP, READY).
  - Function lfsr_step(x, p) for width CRC_W.
  - Default CRC-32 polynomial constant.
- One natural sub-module: crc_lfsr_step_unit, holding the work register, step counter and the done pulse. It is reused by the bench model.
- Table storage is an inferred array with one write port and LANES read ports.

Test Plan:
- Reset defaults (CRC_W=32, POLY=04C11DB7, SHIFT=0) -> busy falls exactly 2304 edges after reset release; then rd_addr 0x00/0x01/0x02/0x03 -> 0x00000000/0x04C11DB7/0x09823B6E/0x0D4326D9 with rd_valid one cycle after rd_req.
- Four lanes in one cycle addressing 0x01, 0xFF, 0x01, 0x80 -> all four valid next cycle; lanes 0 and 2 equal. Every T[i^j] == T[i]^T[j] over a random sweep of 1000 pairs.
- cfg_poly=0x1EDC6F41, cfg_shift=1 -> busy for 4352 cycles; all 256 entries match the golden model (16 LFSR steps each).
- rd_req held high during a fill -> rd_valid stays 0 and rd_data unchanged; cfg_valid during the fill -> ignored, config unchanged after completion.
- rstn pulsed mid-fill at idx 100 of a reconfig -> fill restarts from idx 0 with the POLY/SHIFT defaults; the final table equals the default table.
- CRC_W=16, POLY=0x1021 -> T[1]=0x1021, T[0x80]=0x9188 after a 2304-cycle fill.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC slicing-table generator: fill FSM states,
// the default CRC-32 polynomial and a single MSB-first LFSR step.
package crc_pkg;

    typedef enum logic [1:0] {
        FILL_LOAD,
        FILL_STEP,
        READY
    } fill_state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    // x and p carry the CRC in their low w bits; the result is masked back to w bits.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x, input logic [31:0] p,
                                              input int w);
        logic [31:0] mask;
        logic [31:0] y;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        y = x << 1;
        if ((x & (32'd1 << (w - 1))) != 32'd0) begin
            y = y ^ p;
        end
        return y & mask;
    endfunction

endpackage

// File: rtl/crc_lfsr_step_unit.sv
// Work register plus step counter: advances one LFSR step per cycle and
// flags the step that produces the finished table entry.
module crc_lfsr_step_unit
    import crc_pkg::*;
#(
    parameter int CRC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic [CRC_W-1:0] load_val,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] next_val,
    output logic             last,
    output logic             done
);

    logic [CRC_W-1:0] work_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic [31:0]      work_ext;
    logic [31:0]      poly_ext;
    logic [31:0]      step_ext;
    logic             unused_step_hi;

    always_comb begin
        work_ext              = '0;
        poly_ext              = '0;
        work_ext[CRC_W-1:0]   = work_p0;
        poly_ext[CRC_W-1:0]   = poly;
        step_ext              = lfsr_step(work_ext, poly_ext, CRC_W);
    end

    assign next_val       = step_ext[CRC_W-1:0];
    assign unused_step_hi = ^step_ext;
    assign last           = (cnt_p0 == '0);
    assign done           = step && last;

    // stage p0: work value and remaining-step count
    always_ff @(posedge clk) begin
        if (load) begin
            work_p0 <= load_val;
            cnt_p0  <= load_cnt;
        end else if (step) begin
            work_p0 <= next_val;
            cnt_p0  <= cnt_p0 - 1'b1;
        end
    end

endmodule

// File: rtl/crc_slice_table_gen.sv
// Self-filling 256-entry CRC slicing table: builds T[i] from the active
// polynomial/byte-advance config, then serves LANES registered lookups.
module crc_slice_table_gen
    import crc_pkg::*;
#(
    parameter int              CRC_W   = 32,
    parameter logic [31:0]     POLY    = CRC32_POLY,
    parameter int              SHIFT   = 0,
    parameter int              SHIFT_W = 5,
    parameter int              LANES   = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CRC_W-1:0]       cfg_poly,
    input  logic [SHIFT_W-1:0]     cfg_shift,
    output logic                   busy,
    input  logic [LANES-1:0]       rd_req,
    input  logic [LANES*8-1:0]     rd_addr,
    output logic [LANES-1:0]       rd_valid,
    output logic [LANES*CRC_W-1:0] rd_data
);

    localparam int CNT_W = SHIFT_W + 3;

    fill_state_t          state;
    fill_state_t          state_nxt;
    logic [7:0]           idx;
    logic [CRC_W-1:0]     poly_act;
    logic [SHIFT_W-1:0]   shift_act;
    logic                 load;
    logic                 step;
    logic                 cfg_take;
    logic                 ready;
    logic [CRC_W-1:0]     load_val;
    logic [CNT_W-1:0]     load_cnt;
    logic [CRC_W-1:0]     next_val;
    logic                 last;
    logic                 done;
    logic [CRC_W-1:0]     mem [256];
    logic [LANES-1:0]     rd_valid_p1;
    logic [LANES*CRC_W-1:0] rd_data_p1;

    assign ready     = (state == READY);
    assign busy      = !ready;
    assign cfg_ready = ready;
    assign rd_valid  = rd_valid_p1;
    assign rd_data   = rd_data_p1;

    // N-1 = 8*s+7, i.e. the shift count followed by three ones
    assign load_cnt = {shift_act, 3'b111};

    always_comb begin
        load_val               = '0;
        load_val[CRC_W-1 -: 8] = idx;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= FILL_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        cfg_take  = 1'b0;
        case (state)
            FILL_LOAD: begin
                load      = 1'b1;
                state_nxt = FILL_STEP;
            end
            FILL_STEP: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = (idx == 8'hFF) ? READY : FILL_LOAD;
                end
            end
            READY: begin
                if (cfg_valid) begin
                    cfg_take  = 1'b1;
                    state_nxt = FILL_LOAD;
                end
            end
            default: state_nxt = FILL_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            idx       <= '0;
            poly_act  <= POLY[CRC_W-1:0];
            shift_act <= SHIFT_W'(SHIFT);
        end else if (cfg_take) begin
            idx       <= '0;
            poly_act  <= cfg_poly;
            shift_act <= cfg_shift;
        end else if (done && (idx != 8'hFF)) begin
            idx <= idx + 8'd1;
        end
    end

    crc_lfsr_step_unit #(
        .CRC_W (CRC_W),
        .CNT_W (CNT_W)
    ) u_step (
        .clk      (clk),
        .load     (load),
        .step     (step),
        .load_val (load_val),
        .load_cnt (load_cnt),
        .poly     (poly_act),
        .next_val (next_val),
        .last     (last),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (done) begin
            mem[idx] <= next_val;
        end
    end

    // stage p1: registered lookups, dropped while the table is being rebuilt
    always_ff @(posedge clk) begin
        if (rstn) begin
            rd_valid_p1 <= '0;
            rd_data_p1  <= '0;
        end else begin
            for (int n = 0; n < LANES; n++) begin
                rd_valid_p1[n] <= rd_req[n] && ready;
                if (rd_req[n] && ready) begin
                    rd_data_p1[n*CRC_W +: CRC_W] <= mem[rd_addr[n*8 +: 8]];
                end
            end
        end
    end

endmodule
